// File: rtl/instr_fetch_pkg.sv
// Package fetch_pkg: shared types and default constants for the instruction fetch stage.
// The optional request timeout is enabled by defining FETCH_TIMEOUT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_INC      = 32'd4;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd16;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus: request/address from the fetch stage,
// acknowledge/data back from memory.
interface instr_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_timer.sv
// fetch_timer: counts request cycles that go unacknowledged and flags expiry
// on the cycle in which the TIMEOUT_CYC-th such cycle is seen.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timer import fetch_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_r;

  // Waiting-cycle counter: zeroed whenever the requester is not waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and word fetcher feeding the IR register.
// IDLE -> REQ (hold mem_req until ack) -> LOAD (one-cycle ir_ld, advance PC).
// Branch redirects overwrite the PC and flush an in-flight request.
// Optional: define FETCH_TIMEOUT_EN to abandon requests unanswered for
// TIMEOUT_CYC cycles and raise the sticky fetch_err flag.
module instr_fetch import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned PC_INC      = DEFAULT_PC_INC,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic                 branch_valid,
  input  logic [31:0]          branch_target,
  instr_fetch_if.master        mem,
  output logic                 ir_ld,
  output logic [31:0]          ir_data,
  output logic [31:0]          pc,
  output logic                 busy,
  output logic                 fetch_err
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  logic [31:0]  ir_data_r;
  logic         capture_s;
  logic         mem_req_r;
  logic         ir_ld_r;
  logic         busy_r;
  logic         timeout_s;

`ifdef FETCH_TIMEOUT_EN
  logic         fetch_err_r;

  fetch_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_r != REQ),
    .enable  ((state_r == REQ) && !mem.mem_ack),
    .expired (timeout_s)
  );

  // Sticky error: set by a timeout that is not overridden by a branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err_r <= 1'b0;
    end else if (timeout_s && !branch_valid) begin
      fetch_err_r <= 1'b1;
    end else begin
      fetch_err_r <= fetch_err_r;
    end
  end

  assign fetch_err = fetch_err_r;
`else
  assign timeout_s = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state and PC update; branch always wins over ack, fetch and timeout.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (branch_valid) begin
          pc_nxt_s    = branch_target;
          state_nxt_s = IDLE;
        end else if (fetch_en) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (branch_valid) begin
          pc_nxt_s    = branch_target;
          state_nxt_s = IDLE;
        end else if (mem.mem_ack) begin
          capture_s   = 1'b1;
          state_nxt_s = LOAD;
        end else if (timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      LOAD: begin
        if (branch_valid) begin
          pc_nxt_s    = branch_target;
          state_nxt_s = IDLE;
        end else begin
          pc_nxt_s    = pc_r + 32'(PC_INC);
          state_nxt_s = fetch_en ? REQ : IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, PC, IR capture and registered Moore outputs decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      ir_data_r <= 32'h0000_0000;
      mem_req_r <= 1'b0;
      ir_ld_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      ir_data_r <= capture_s ? mem.mem_rdata : ir_data_r;
      mem_req_r <= (state_nxt_s == REQ);
      ir_ld_r   <= (state_nxt_s == LOAD);
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = pc_r;
  assign ir_ld        = ir_ld_r;
  assign ir_data      = ir_data_r;
  assign pc           = pc_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        ir_ld;
  logic [31:0] ir_data;
  logic [31:0] pc;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_if mem_bus();

  instr_fetch #(
    .RESET_PC    (32'h0000_0000),
    .PC_INC      (32'd4),
    .TIMEOUT_CYC (32'd16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem           (mem_bus),
    .ir_ld         (ir_ld),
    .ir_data       (ir_data),
    .pc            (pc),
    .busy          (busy),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    fetch_en          = 1'b0;
    branch_valid      = 1'b0;
    branch_target     = 32'h0000_0000;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_bus.mem_req, ir_ld, busy, fetch_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/ld/busy/err=%b expected 0000",
               {mem_bus.mem_req, ir_ld, busy, fetch_err});
    end
    checks++;
    if (pc !== 32'h0000_0000 || ir_data !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_regs: got pc=%h ir=%h expected 0/0", pc, ir_data);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_en = 1'b1;
    step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h2002_0005;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_bus.mem_req !== 1'b1 || ir_ld !== 1'b0 || mem_bus.mem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_req[%0d]: got req=%b ld=%b addr=%h expected 1 0 %h",
                 k, mem_bus.mem_req, ir_ld, mem_bus.mem_addr, 32'(4 * k));
      end
      step();
      checks++;
      if (ir_ld !== 1'b1 || ir_data !== 32'h2002_0005 || mem_bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL seq_load[%0d]: got ld=%b ir=%h req=%b expected 1 20020005 0",
                 k, ir_ld, ir_data, mem_bus.mem_req);
      end
      step();
      checks++;
      if (pc !== 32'(4 * (k + 1))) begin
        errors++;
        $display("FAIL seq_pc[%0d]: got %h expected %h", k, pc, 32'(4 * (k + 1)));
      end
    end
    fetch_en        = 1'b0;
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    int loads;
    do_reset();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0000 || ir_ld !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got req=%b addr=%h ld=%b expected 1 0 0",
                 i, mem_bus.mem_req, mem_bus.mem_addr, ir_ld);
      end
      step();
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hCAFE_0123;
    step();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (ir_ld !== 1'b1 || ir_data !== 32'hCAFE_0123) begin
      errors++;
      $display("FAIL wait_load: got ld=%b ir=%h expected 1 cafe0123", ir_ld, ir_data);
    end
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ir_ld === 1'b1) loads++;
    end
    checks++;
    if (loads !== 0 || pc !== 32'h0000_0004 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_after: got extra_loads=%0d pc=%h busy=%b expected 0 4 0", loads, pc, busy);
    end
  endtask

  task automatic test_branch_in_req();
    do_reset();
    fetch_en = 1'b1;
    step();
    fetch_en          = 1'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1111_2222;
    branch_valid      = 1'b1;
    branch_target     = 32'h0000_0040;
    step();
    branch_valid    = 1'b0;
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (ir_ld !== 1'b0 || mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h0000_0040 ||
        ir_data !== 32'h0000_0000) begin
      errors++;
      $display("FAIL br_req_flush: got ld=%b req=%b busy=%b pc=%h ir=%h expected 0 0 0 40 0",
               ir_ld, mem_bus.mem_req, busy, pc, ir_data);
    end
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0040) begin
      errors++;
      $display("FAIL br_req_refetch: got req=%b addr=%h expected 1 40", mem_bus.mem_req, mem_bus.mem_addr);
    end
  endtask

  task automatic test_branch_in_load();
    do_reset();
    fetch_en = 1'b1;
    step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hABCD_EF01;
    step();
    mem_bus.mem_ack = 1'b0;
    branch_valid    = 1'b1;
    branch_target   = 32'h0000_0100;
    checks++;
    if (ir_ld !== 1'b1 || ir_data !== 32'hABCD_EF01) begin
      errors++;
      $display("FAIL br_load_ld: got ld=%b ir=%h expected 1 abcdef01", ir_ld, ir_data);
    end
    step();
    branch_valid = 1'b0;
    fetch_en     = 1'b0;
    checks++;
    if (pc !== 32'h0000_0100 || mem_bus.mem_req !== 1'b0 || ir_data !== 32'hABCD_EF01) begin
      errors++;
      $display("FAIL br_load_pc: got pc=%h req=%b ir=%h expected 100 0 abcdef01",
               pc, mem_bus.mem_req, ir_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    fetch_en      = 1'b1;
    step();
    branch_valid = 1'b0;
    checks++;
    if (mem_bus.mem_req !== 1'b0 || pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_priority: got req=%b pc=%h expected 0 fffffffc", mem_bus.mem_req, pc);
    end
    step();
    fetch_en        = 1'b0;
    mem_bus.mem_ack = 1'b1;
    checks++;
    if (mem_bus.mem_addr !== 32'hFFFF_FFFC || mem_bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_addr: got req=%b addr=%h expected 1 fffffffc", mem_bus.mem_req, mem_bus.mem_addr);
    end
    step();
    mem_bus.mem_ack = 1'b0;
    step();
    checks++;
    if (pc !== 32'h0000_0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%h busy=%b expected 0 0", pc, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0080;
    step();
    branch_valid = 1'b0;
    fetch_en     = 1'b1;
    step();
    fetch_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h0000_0000 || ir_ld !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got req=%b busy=%b pc=%h ld=%b expected 0 0 0 0",
               mem_bus.mem_req, busy, pc, ir_ld);
    end
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (ir_ld !== 1'b0 || busy !== 1'b0 || ir_data !== 32'h0000_0000) begin
      errors++;
      $display("FAIL late_ack: got ld=%b busy=%b ir=%h expected 0 0 0", ir_ld, busy, ir_data);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    do_reset();
    fetch_en = 1'b1;
    step();
    fetch_en   = 1'b0;
    req_cycles = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      if (mem_bus.mem_req === 1'b1 && fetch_err === 1'b0) req_cycles++;
      step();
    end
    checks++;
    if (req_cycles !== 16 || mem_bus.mem_req !== 1'b0 || fetch_err !== 1'b1 ||
        pc !== 32'h0000_0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got req_cycles=%0d req=%b err=%b pc=%h busy=%b expected 16 0 1 0 0",
               req_cycles, mem_bus.mem_req, fetch_err, pc, busy);
    end
    repeat (5) step();
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b expected 1", fetch_err);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req === 1'b1 && fetch_err === 1'b0) req_cycles++;
      step();
    end
    checks++;
    if (req_cycles !== 20 || mem_bus.mem_req !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got req_cycles=%0d req=%b err=%b expected 20 1 0",
               req_cycles, mem_bus.mem_req, fetch_err);
    end
`endif
  endtask

  // Randomized run against a model of the fetch rules: a pending request
  // either gets flushed by a branch or delivers a word; a delivered word
  // advances the PC by 4 (or to the branch target) after its load cycle.
  task automatic test_random();
    bit          m_req;
    bit          m_ld;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    int          m_wait;
    bit          fen;
    bit          br;
    bit          ack;
    logic [31:0] tgt;
    logic [31:0] rdata;
    do_reset();
    m_req  = 1'b0;
    m_ld   = 1'b0;
    m_pc   = 32'h0000_0000;
    m_ir   = 32'h0000_0000;
    m_wait = 0;
    step();
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (mem_bus.mem_req !== m_req || ir_ld !== m_ld || busy !== (m_req || m_ld) ||
          pc !== m_pc || ir_data !== m_ir || (m_req && mem_bus.mem_addr !== m_pc)) begin
        errors++;
        $display("FAIL rand[%0d]: got req=%b ld=%b busy=%b pc=%h ir=%h addr=%h expected %b %b %b %h %h",
                 cyc, mem_bus.mem_req, ir_ld, busy, pc, ir_data, mem_bus.mem_addr,
                 m_req, m_ld, (m_req || m_ld), m_pc, m_ir);
      end
      fen   = ($urandom_range(0, 3) != 0);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      rdata = $urandom;
      if (m_req) ack = ($urandom_range(0, 2) == 0) || (m_wait >= 4);
      else       ack = ($urandom_range(0, 3) == 0);
      fetch_en          = fen;
      branch_valid      = br;
      branch_target     = tgt;
      mem_bus.mem_ack   = ack;
      mem_bus.mem_rdata = rdata;
      if (m_req) begin
        if (br) begin
          m_pc  = tgt;
          m_req = 1'b0;
        end else if (ack) begin
          m_ir  = rdata;
          m_req = 1'b0;
          m_ld  = 1'b1;
        end
        m_wait = m_req ? m_wait + 1 : 0;
      end else if (m_ld) begin
        m_ld  = 1'b0;
        m_pc  = br ? tgt : m_pc + 32'd4;
        m_req = fen && !br;
      end else begin
        if (br) m_pc = tgt;
        else if (fen) m_req = 1'b1;
      end
      step();
    end
    fetch_en        = 1'b0;
    branch_valid    = 1'b0;
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err: got err=%b expected 0", fetch_err);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch_in_req();
    test_branch_in_load();
    test_wrap();
    test_async_reset();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits directly upstream of the 32-bit IR register. It holds the PC and issues word reads to instruction memory over a req/ack handshake. Each fetched word is presented on ir_data with a one-cycle ir_ld strobe, wired to the IR register's datain/LD. Branch redirects from the control unit overwrite the PC and flush any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment per sequential fetch
TIMEOUT_CYC, 16, REQ-state cycle limit (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
fetch_en  in  1  request next sequential fetch
branch_valid  in  1  redirect PC this cycle
branch_target  in  32  new PC when branch_valid=1
mem_req  out  1  read request to instruction memory
mem_addr  out  32  read address (= pc while mem_req=1)
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  32  instruction word
ir_ld  out  1  one-cycle load strobe to IR register
ir_data  out  32  fetched instruction
pc  out  32  current PC
busy  out  1  state != IDLE
fetch_err  out  1  sticky timeout flag (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, ir_data=0, mem_req=0, ir_ld=0, busy=0, fetch_err=0. Outputs drop immediately, not at the next edge. An in-flight fetch is abandoned and a late mem_ack is ignored.
- Moore FSM with states IDLE, REQ, LOAD. mem_req=(state==REQ). ir_ld=(state==LOAD). mem_addr=pc.
- IDLE:
  - fetch_en=1 -> REQ.
  - branch_valid=1 -> pc<=branch_target and stay IDLE. Branch has priority over fetch_en in the same cycle.
- REQ:
  - mem_req held high and mem_addr stable until mem_ack.
  - mem_ack=1 and no branch -> ir_data<=mem_rdata, go to LOAD.
  - mem_ack=0 -> stay in REQ.
  - branch_valid=1 (with or without ack) -> flush: data discarded, no ir_ld, pc<=branch_target, go to IDLE.
- LOAD:
  - ir_ld=1 for exactly one cycle. ir_data is valid and is held until the next LOAD.
  - pc<=pc+PC_INC, or branch_target if branch_valid=1. The loaded instruction is still valid on a branch.
  - Next state is REQ if fetch_en=1 (and no branch), else IDLE.
- Latency: fetch_en at edge N -> mem_req in cycle N+1. Ack in that cycle -> ir_ld in N+2. Sustained zero-wait throughput is one instruction per 2 cycles.
- Arithmetic: pc is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. No alignment check; branch_target is used verbatim.
- mem_ack outside REQ is ignored. fetch_en outside IDLE/LOAD is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a cycle counter clears on entry to REQ and increments each REQ cycle without ack. When TIMEOUT_CYC cycles elapse without ack: mem_req drops, fetch_err<=1 (sticky until reset), state->IDLE, pc unchanged. A branch still takes priority over timeout.
- Undefined: no counter; REQ waits indefinitely; fetch_err is constant 0.

Decomposition:
- Package fetch_pkg: state encoding (IDLE=2'd0, REQ=2'd1, LOAD=2'd2), default RESET_PC, PC_INC constants.
- Sub-module fetch_timer: the timeout counter (clk, reset, clear, enable -> expired). It is instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release, fetch_en=1 held, mem_ack=1 every REQ cycle, mem_rdata=0x2002_0005 -> mem_addr=0x0 in cycle 1, ir_ld in cycle 2 with ir_data=0x2002_0005, pc=0x4 next; ir_ld repeats every 2 cycles with pc 0x8, 0xC.
- mem_ack delayed 3 cycles -> mem_req and mem_addr stable for 3 cycles; single ir_ld after ack; no duplicate loads.
- branch_valid with target 0x0000_0040 during REQ, same cycle as mem_ack -> no ir_ld, pc=0x40, IDLE; next fetch issues mem_addr=0x40.
- Branch in LOAD, target 0x100 -> ir_ld still asserted; pc=0x100 (not pc+4).
- pc forced via branch to 0xFFFF_FFFC, one fetch -> pc wraps to 0x0.
- Reset asserted mid-REQ -> mem_req falls without clock edge; pc=RESET_PC. With FETCH_TIMEOUT_EN and no ack for 16 cycles -> mem_req drops, fetch_err=1 and stays 1.
